// File: rtl/lsu_load_tracker.sv
// Load tracking back end for the LSU. Allocates a tag per warp load, merges partial
// per-lane dcache responses (aligned and sign-extended on arrival) and commits whole loads.
module lsu_load_tracker #(
    parameter int NUM_THREADS = 4,
    parameter int QUEUE_SIZE  = 8,
    parameter int TAG_W       = $clog2(QUEUE_SIZE),
    parameter int META_W      = 40,
    parameter int IN_ORDER    = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    input  logic [NUM_THREADS-1:0]           req_tmask,
    input  logic [NUM_THREADS*2-1:0]         req_offset,
    input  logic [1:0]                       req_sext,
    input  logic [META_W-1:0]                req_meta,
    output logic                             req_ready,
    output logic                             mem_req_valid,
    output logic [NUM_THREADS-1:0]           mem_req_tmask,
    output logic [TAG_W-1:0]                 mem_req_tag,
    input  logic                             mem_req_ready,
    input  logic                             mem_rsp_valid,
    input  logic [NUM_THREADS-1:0]           mem_rsp_tmask,
    input  logic [TAG_W-1:0]                 mem_rsp_tag,
    input  logic [NUM_THREADS*32-1:0]        mem_rsp_data,
    output logic                             mem_rsp_ready,
    output logic                             cmt_valid,
    output logic [NUM_THREADS-1:0]           cmt_tmask,
    output logic [META_W-1:0]                cmt_meta,
    output logic [NUM_THREADS*32-1:0]        cmt_data,
    input  logic                             cmt_ready,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]  pending_count
);

    localparam int CNT_W = $clog2(QUEUE_SIZE + 1);

    logic [QUEUE_SIZE-1:0]       valid_reg;
    logic [NUM_THREADS-1:0]      tmask_reg     [QUEUE_SIZE];
    logic [NUM_THREADS-1:0]      remaining_reg [QUEUE_SIZE];
    logic [NUM_THREADS*2-1:0]    offset_reg    [QUEUE_SIZE];
    logic [1:0]                  sext_reg      [QUEUE_SIZE];
    logic [META_W-1:0]           meta_reg      [QUEUE_SIZE];
    logic [NUM_THREADS*32-1:0]   data_reg      [QUEUE_SIZE];
    logic [TAG_W-1:0]            fifo_reg      [QUEUE_SIZE];
    logic [TAG_W-1:0]            head_reg;
    logic [TAG_W-1:0]            tail_reg;

    logic                        cmt_valid_reg;
    logic [NUM_THREADS-1:0]      cmt_tmask_reg;
    logic [META_W-1:0]           cmt_meta_reg;
    logic [NUM_THREADS*32-1:0]   cmt_data_reg;
    logic [CNT_W-1:0]            pending_reg;
    logic                        mem_rsp_ready_reg;

    logic                        full;
    logic                        accept;
    logic [TAG_W-1:0]            alloc_idx;
    logic [QUEUE_SIZE-1:0]       complete_vec;
    logic                        cand_valid;
    logic [TAG_W-1:0]            cand_idx;
    logic                        cmt_load;
    logic                        cmt_fire;
    logic [NUM_THREADS-1:0]      lane_hit;
    logic [NUM_THREADS*32-1:0]   lane_flat;

    // Lowest-index free slot; a slot freed this edge only shows up next cycle.
    always_comb begin
        alloc_idx = '0;
        for (int q = QUEUE_SIZE - 1; q >= 0; q--) begin
            if (!valid_reg[q]) alloc_idx = TAG_W'(q);
        end
    end

    assign full          = &valid_reg;
    assign req_ready     = !full && (mem_req_ready || (req_tmask == '0));
    assign accept        = req_valid && req_ready;
    assign mem_req_valid = req_valid && !full && (|req_tmask);
    assign mem_req_tmask = req_tmask;
    assign mem_req_tag   = alloc_idx;

    genvar gi;
    generate
        for (gi = 0; gi < QUEUE_SIZE; gi++) begin : g_complete
            assign complete_vec[gi] = valid_reg[gi] && (remaining_reg[gi] == '0);
        end

        if (IN_ORDER != 0) begin : g_in_order
            assign cand_idx   = fifo_reg[head_reg];
            assign cand_valid = complete_vec[cand_idx];
        end else begin : g_any_order
            always_comb begin
                cand_idx   = '0;
                cand_valid = 1'b0;
                for (int q = QUEUE_SIZE - 1; q >= 0; q--) begin
                    if (complete_vec[q]) begin
                        cand_idx   = TAG_W'(q);
                        cand_valid = 1'b1;
                    end
                end
            end
        end

        // Per-lane alignment and extension of the incoming beat.
        for (gi = 0; gi < NUM_THREADS; gi++) begin : g_lane
            logic [1:0]  lane_off;
            logic [1:0]  lane_sext;
            logic [31:0] lane_shift;
            assign lane_off   = offset_reg[mem_rsp_tag][2*gi +: 2];
            assign lane_sext  = sext_reg[mem_rsp_tag];
            assign lane_shift = mem_rsp_data[32*gi +: 32] >> {lane_off, 3'b000};
            assign lane_flat[32*gi +: 32] =
                (lane_sext == 2'd1) ? {{24{lane_shift[7]}},  lane_shift[7:0]}  :
                (lane_sext == 2'd2) ? {{16{lane_shift[15]}}, lane_shift[15:0]} :
                                      lane_shift;
            assign lane_hit[gi] = mem_rsp_valid && mem_rsp_ready_reg && valid_reg[mem_rsp_tag]
                                  && mem_rsp_tmask[gi] && remaining_reg[mem_rsp_tag][gi];
        end
    endgenerate

    assign cmt_load = cand_valid && (!cmt_valid_reg || cmt_ready);
    assign cmt_fire = cmt_valid_reg && cmt_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg         <= '0;
            head_reg          <= '0;
            tail_reg          <= '0;
            cmt_valid_reg     <= 1'b0;
            cmt_tmask_reg     <= '0;
            cmt_meta_reg      <= '0;
            cmt_data_reg      <= '0;
            pending_reg       <= '0;
            mem_rsp_ready_reg <= 1'b0;
            for (int q = 0; q < QUEUE_SIZE; q++) begin
                tmask_reg[q]     <= '0;
                remaining_reg[q] <= '0;
                offset_reg[q]    <= '0;
                sext_reg[q]      <= '0;
                meta_reg[q]      <= '0;
                data_reg[q]      <= '0;
                fifo_reg[q]      <= '0;
            end
        end else begin
            mem_rsp_ready_reg <= 1'b1;

            if (accept) begin
                valid_reg[alloc_idx]     <= 1'b1;
                tmask_reg[alloc_idx]     <= req_tmask;
                remaining_reg[alloc_idx] <= req_tmask;
                offset_reg[alloc_idx]    <= req_offset;
                sext_reg[alloc_idx]      <= req_sext;
                meta_reg[alloc_idx]      <= req_meta;
                data_reg[alloc_idx]      <= '0;
                if (IN_ORDER != 0) begin
                    fifo_reg[tail_reg] <= alloc_idx;
                    tail_reg           <= tail_reg + 1'b1;
                end
            end

            // The beat targets an allocated entry, never the one being allocated.
            for (int l = 0; l < NUM_THREADS; l++) begin
                if (lane_hit[l]) begin
                    data_reg[mem_rsp_tag][32*l +: 32] <= lane_flat[32*l +: 32];
                    remaining_reg[mem_rsp_tag][l]     <= 1'b0;
                end
            end

            if (cmt_load) begin
                valid_reg[cand_idx] <= 1'b0;
                cmt_valid_reg       <= 1'b1;
                cmt_tmask_reg       <= tmask_reg[cand_idx];
                cmt_meta_reg        <= meta_reg[cand_idx];
                cmt_data_reg        <= data_reg[cand_idx];
                if (IN_ORDER != 0) head_reg <= head_reg + 1'b1;
            end else if (cmt_fire) begin
                cmt_valid_reg <= 1'b0;
            end

            if (accept && !cmt_fire) begin
                pending_reg <= pending_reg + 1'b1;
            end else if (!accept && cmt_fire) begin
                pending_reg <= pending_reg - 1'b1;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!reset)
        mem_rsp_valid |-> valid_reg[mem_rsp_tag]);

    assign mem_rsp_ready = mem_rsp_ready_reg;
    assign cmt_valid     = cmt_valid_reg;
    assign cmt_tmask     = cmt_tmask_reg;
    assign cmt_meta      = cmt_meta_reg;
    assign cmt_data      = cmt_data_reg;
    assign pending_count = pending_reg;

endmodule

// File: tb/tb_lsu_load_tracker.sv
// Directed bench for lsu_load_tracker: an in-order and an any-order instance share
// one stimulus stream; expected values are hand-computed constants.
module tb_lsu_load_tracker;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic [3:0]   req_tmask = '0;
    logic [7:0]   req_offset = '0;
    logic [1:0]   req_sext = '0;
    logic [39:0]  req_meta = '0;
    logic         mem_req_ready = 1'b1;
    logic         mem_rsp_valid = 1'b0;
    logic [3:0]   mem_rsp_tmask = '0;
    logic [2:0]   mem_rsp_tag = '0;
    logic [127:0] mem_rsp_data = '0;
    logic         cmt_ready = 1'b1;

    logic         req_ready, mem_req_valid, mem_rsp_ready, cmt_valid;
    logic [3:0]   mem_req_tmask, cmt_tmask, pending_count;
    logic [2:0]   mem_req_tag;
    logic [39:0]  cmt_meta;
    logic [127:0] cmt_data;

    logic         ooo_req_ready, ooo_mem_req_valid, ooo_mem_rsp_ready, ooo_cmt_valid;
    logic [3:0]   ooo_mem_req_tmask, ooo_cmt_tmask, ooo_pending_count;
    logic [2:0]   ooo_mem_req_tag;
    logic [39:0]  ooo_cmt_meta;
    logic [127:0] ooo_cmt_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_load_tracker #(.IN_ORDER(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_tmask(req_tmask), .req_offset(req_offset),
        .req_sext(req_sext), .req_meta(req_meta), .req_ready(req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_tmask(mem_req_tmask),
        .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tmask(mem_rsp_tmask),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_ready(mem_rsp_ready),
        .cmt_valid(cmt_valid), .cmt_tmask(cmt_tmask), .cmt_meta(cmt_meta),
        .cmt_data(cmt_data), .cmt_ready(cmt_ready), .pending_count(pending_count)
    );

    lsu_load_tracker #(.IN_ORDER(0)) dut_ooo (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_tmask(req_tmask), .req_offset(req_offset),
        .req_sext(req_sext), .req_meta(req_meta), .req_ready(ooo_req_ready),
        .mem_req_valid(ooo_mem_req_valid), .mem_req_tmask(ooo_mem_req_tmask),
        .mem_req_tag(ooo_mem_req_tag), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tmask(mem_rsp_tmask),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_ready(ooo_mem_rsp_ready),
        .cmt_valid(ooo_cmt_valid), .cmt_tmask(ooo_cmt_tmask), .cmt_meta(ooo_cmt_meta),
        .cmt_data(ooo_cmt_data), .cmt_ready(cmt_ready), .pending_count(ooo_pending_count)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] tm, input logic [7:0] off, input logic [1:0] sx,
                         input logic [39:0] meta, input logic [2:0] exp_tag);
        req_valid  = 1'b1;
        req_tmask  = tm;
        req_offset = off;
        req_sext   = sx;
        req_meta   = meta;
        #1;
        check("req_ready", req_ready, 1'b1);
        if (tm != 4'b0) begin
            check("mem_req_tag", mem_req_tag, exp_tag);
            check("ooo_mem_req_tag", ooo_mem_req_tag, exp_tag);
        end
        $display("req  tmask=%b meta=%0h tag=%0d", tm, meta, mem_req_tag);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic beat(input logic [2:0] tag, input logic [3:0] tm, input logic [127:0] data);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = tag;
        mem_rsp_tmask = tm;
        mem_rsp_data  = data;
        $display("rsp  tag=%0d tmask=%b data=%h", tag, tm, data);
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
    endtask

    logic [39:0] qa_meta[$];
    logic [39:0] qb_meta[$];
    logic [31:0] qa_word[$];
    logic [31:0] ord_word  [3] = '{32'h12345678, 32'h80010000, 32'h00007F00};
    logic [39:0] exp_a_meta[3] = '{40'd1, 40'd2, 40'd3};
    logic [39:0] exp_b_meta[3] = '{40'd3, 40'd2, 40'd1};
    logic [31:0] exp_a_word[3] = '{32'h12345678, 32'hFFFF8001, 32'h0000007F};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        #1 reset = 1'b0;
        #1;
        check("rst_cmt_valid", cmt_valid, 1'b0);
        check("rst_pending", pending_count, 4'd0);
        check("rst_rsp_ready", mem_rsp_ready, 1'b0);
        check("rst_cmt_data", cmt_data, 128'h0);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rsp_ready_after_rst", mem_rsp_ready, 1'b1);

        // Single full load
        issue(4'b1111, 8'h00, 2'd0, 40'h12_3456_789A, 3'd0);
        check("t1_pending", pending_count, 4'd1);
        beat(3'd0, 4'b1111, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        check("t1_cmt_early", cmt_valid, 1'b0);
        tick();
        check("t1_cmt_valid", cmt_valid, 1'b1);
        check("t1_cmt_data", cmt_data, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        check("t1_cmt_tmask", cmt_tmask, 4'b1111);
        check("t1_cmt_meta", cmt_meta, 40'h12_3456_789A);
        check("t1_pending_hold", pending_count, 4'd1);
        $display("cmt  meta=%0h data=%h", cmt_meta, cmt_data);
        tick();
        check("t1_cmt_done", cmt_valid, 1'b0);
        check("t1_pending_end", pending_count, 4'd0);

        // Split beats with byte sign extension and lane-0 offset 3
        issue(4'b1111, 8'h03, 2'd1, 40'hAA, 3'd0);
        beat(3'd0, 4'b0011, {4{32'h80000000}});
        check("t2_no_cmt_a", cmt_valid, 1'b0);
        tick();
        check("t2_no_cmt_b", cmt_valid, 1'b0);
        tick();
        beat(3'd0, 4'b1100, {32'h0000007F, 32'h000000F0, 32'h0, 32'h0});
        check("t2_no_cmt_c", cmt_valid, 1'b0);
        tick();
        check("t2_cmt_valid", cmt_valid, 1'b1);
        check("t2_cmt_data", cmt_data, {32'h0000007F, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFF80});
        $display("cmt  meta=%0h data=%h", cmt_meta, cmt_data);
        tick();
        check("t2_cmt_done", cmt_valid, 1'b0);

        // Empty tmask: no dcache request, accepted regardless of mem_req_ready
        mem_req_ready = 1'b0;
        req_valid = 1'b1;
        req_tmask = 4'b0001;
        req_meta  = 40'h77;
        #1;
        check("t3_rdy_blocked", req_ready, 1'b0);
        check("t3_mreq_valid", mem_req_valid, 1'b1);
        req_tmask = 4'b0000;
        #1;
        check("t3_rdy_zero", req_ready, 1'b1);
        check("t3_mreq_zero", mem_req_valid, 1'b0);
        tick();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        check("t3_cmt_early", cmt_valid, 1'b0);
        tick();
        check("t3_cmt_valid", cmt_valid, 1'b1);
        check("t3_cmt_meta", cmt_meta, 40'h77);
        check("t3_cmt_data", cmt_data, 128'h0);
        check("t3_cmt_tmask", cmt_tmask, 4'b0000);
        tick();

        // Ordering: responses 2,1,0
        issue(4'b0001, 8'h00, 2'd0, 40'd1, 3'd0);
        issue(4'b0001, 8'h02, 2'd2, 40'd2, 3'd1);
        issue(4'b0001, 8'h01, 2'd1, 40'd3, 3'd2);
        check("t4_pending", pending_count, 4'd3);
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 3) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_tag   = 3'(2 - cyc);
                mem_rsp_tmask = 4'b0001;
                mem_rsp_data  = {96'h0, ord_word[2 - cyc]};
            end else begin
                mem_rsp_valid = 1'b0;
            end
            #1;
            if (cmt_valid) begin
                qa_meta.push_back(cmt_meta);
                qa_word.push_back(cmt_data[31:0]);
                $display("cmt  in-order meta=%0h data=%h", cmt_meta, cmt_data[31:0]);
            end
            if (ooo_cmt_valid) begin
                qb_meta.push_back(ooo_cmt_meta);
                $display("cmt  any-order meta=%0h", ooo_cmt_meta);
            end
            tick();
        end
        check("t4_a_count", qa_meta.size(), 3);
        check("t4_b_count", qb_meta.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < qa_meta.size()) begin
                check("t4_a_meta", qa_meta[i], exp_a_meta[i]);
                check("t4_a_word", qa_word[i], exp_a_word[i]);
            end
            if (i < qb_meta.size()) check("t4_b_meta", qb_meta[i], exp_b_meta[i]);
        end
        check("t4_pending_end", pending_count, 4'd0);

        // Backpressure with two complete entries
        cmt_ready = 1'b0;
        issue(4'b0011, 8'h00, 2'd0, 40'h44, 3'd0);
        issue(4'b0011, 8'h00, 2'd0, 40'h55, 3'd1);
        beat(3'd0, 4'b0011, {64'h0, 32'hCAFE0001, 32'hBEEF0002});
        beat(3'd1, 4'b0011, {64'h0, 32'h01020304, 32'h05060708});
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", cmt_valid, 1'b1);
            check("t5_hold_meta", cmt_meta, 40'h44);
            check("t5_hold_data", cmt_data, {64'h0, 32'hCAFE0001, 32'hBEEF0002});
            check("t5_hold_pending", pending_count, 4'd2);
            tick();
        end
        cmt_ready = 1'b1;
        #1;
        check("t5_rel_first", cmt_meta, 40'h44);
        $display("cmt  meta=%0h data=%h", cmt_meta, cmt_data);
        tick();
        check("t5_rel_valid", cmt_valid, 1'b1);
        check("t5_rel_second", cmt_meta, 40'h55);
        check("t5_rel_data", cmt_data, {64'h0, 32'h01020304, 32'h05060708});
        $display("cmt  meta=%0h data=%h", cmt_meta, cmt_data);
        tick();
        check("t5_done", cmt_valid, 1'b0);
        check("t5_pending_end", pending_count, 4'd0);

        // Full queue; tag 5 completes and is reused by the any-order instance
        for (int k = 0; k < 8; k++) issue(4'b0001, 8'h00, 2'd0, 40'h100 + 40'(k), 3'(k));
        check("t6_pending_full", pending_count, 4'd8);
        req_valid = 1'b1;
        req_tmask = 4'b0001;
        req_meta  = 40'h999;
        #1;
        check("t6_full_rdy", req_ready, 1'b0);
        check("t6_full_mreq", mem_req_valid, 1'b0);
        check("t6_full_rdy_ooo", ooo_req_ready, 1'b0);
        check("t6_full_mreq_ooo", ooo_mem_req_valid, 1'b0);
        beat(3'd5, 4'b0001, {96'h0, 32'h55});
        check("t6_ooo_no_cmt", ooo_cmt_valid, 1'b0);
        check("t6_ooo_still_full", ooo_req_ready, 1'b0);
        tick();
        check("t6_ooo_cmt", ooo_cmt_valid, 1'b1);
        check("t6_ooo_cmt_meta", ooo_cmt_meta, 40'h105);
        check("t6_ooo_realloc_rdy", ooo_req_ready, 1'b1);
        check("t6_ooo_realloc_tag", ooo_mem_req_tag, 3'd5);
        check("t6_ooo_realloc_mreq", ooo_mem_req_valid, 1'b1);
        check("t6_inorder_full", req_ready, 1'b0);
        tick();
        req_valid = 1'b0;
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();

        // Asynchronous reset with three pending entries and a held commit
        cmt_ready = 1'b0;
        issue(4'b0001, 8'h00, 2'd0, 40'h201, 3'd0);
        issue(4'b0001, 8'h00, 2'd0, 40'h202, 3'd1);
        issue(4'b0001, 8'h00, 2'd0, 40'h203, 3'd2);
        beat(3'd0, 4'b0001, {96'h0, 32'hABCD});
        tick();
        check("t7_pre_valid", cmt_valid, 1'b1);
        check("t7_pre_pending", pending_count, 4'd3);
        #2;
        reset = 1'b0;
        #1;
        check("t7_rst_valid", cmt_valid, 1'b0);
        check("t7_rst_pending", pending_count, 4'd0);
        check("t7_rst_valid_ooo", ooo_cmt_valid, 1'b0);
        check("t7_rst_pending_ooo", ooo_pending_count, 4'd0);
        check("t7_rst_rsp_ready", mem_rsp_ready, 1'b0);
        @(posedge clk); @(posedge clk);
        #1;
        reset = 1'b1;
        cmt_ready = 1'b1;
        tick();
        issue(4'b1111, 8'h00, 2'd0, 40'h300, 3'd0);
        check("t7_post_pending", pending_count, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
